// File: rtl/mag_pkg.sv
// Shared types and constants for the magnetron cook-cycle controller.
// The state encoding is visible on the controller's state output.
package mag_pkg;

    typedef enum logic [1:0] {
        MAG_IDLE  = 2'd0,
        MAG_COOK  = 2'd1,
        MAG_PAUSE = 2'd2,
        MAG_DONE  = 2'd3
    } mag_state_t;

    localparam int DUTY_STEPS_DEFAULT = 10;

    // Power levels above the duty window length behave as "always on".
    function automatic logic [3:0] clamp_power(input logic [3:0] p, input logic [3:0] max_p);
        return (p > max_p) ? max_p : p;
    endfunction

endpackage

// File: rtl/mag_tick_gen.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled and flags the last count.
// sec_tick marks the cycle whose clock edge wraps the counter when en is high.
module mag_tick_gen #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic sec_tick
);

    localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TOP = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (count_q == TOP) ? '0 : count_q + 1'b1;
        end
    end

    // Not gated by en: a paused prescaler parked at TOP ticks on the first enabled edge.
    assign sec_tick = (count_q == TOP);

endmodule

// File: rtl/mag_controller.sv
// Cook-cycle sequencer: loads time/power, counts seconds down and drives the
// magnetron SR latch with one-cycle set/reset pulses inside power-level duty windows.
module mag_controller
    import mag_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int TIME_W        = 12,
    parameter int DUTY_STEPS    = DUTY_STEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              door_closed,
    input  logic              start,
    input  logic              stop,
    input  logic [TIME_W-1:0] time_in,
    input  logic [3:0]        power_in,
    output logic              mag_set,
    output logic              mag_reset,
    output logic              mag_on,
    output logic [TIME_W-1:0] remaining,
    output logic [1:0]        state,
    output logic              done
);

    localparam logic [3:0] DUTY_MAX  = 4'(DUTY_STEPS);
    localparam logic [3:0] DUTY_LAST = 4'(DUTY_STEPS - 1);

    mag_state_t        state_q, state_d;
    logic [TIME_W-1:0] remaining_q, remaining_d;
    logic [3:0]        power_q, power_d;
    logic [3:0]        duty_q, duty_d;
    logic              start_q, stop_q;
    logic              mag_set_q, mag_reset_q, mag_on_q, done_q;

    logic start_rise, stop_rise, in_cook, sec_tick, tick;
    logic expire, pause_evt, prescale_en, prescale_clr, want_d;

    always_comb begin
        start_rise   = start & ~start_q;
        stop_rise    = stop & ~stop_q;
        in_cook      = (state_q == MAG_COOK);
        tick         = in_cook & sec_tick;
        expire       = tick & (remaining_q == TIME_W'(1));
        // Expiry outranks a pause arriving on the same edge.
        pause_evt    = in_cook & (~door_closed | stop_rise) & ~expire;
        prescale_en  = in_cook & ~pause_evt;
        prescale_clr = (state_q == MAG_IDLE) | (state_q == MAG_DONE);
    end

    mag_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (prescale_en),
        .clr     (prescale_clr),
        .sec_tick(sec_tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        power_d     = power_q;
        duty_d      = duty_q;
        case (state_q)
            MAG_IDLE: begin
                if (start_rise && !stop_rise && door_closed && (|time_in) && (|power_in)) begin
                    state_d     = MAG_COOK;
                    remaining_d = time_in;
                    power_d     = clamp_power(power_in, DUTY_MAX);
                    duty_d      = '0;
                end
            end
            MAG_COOK: begin
                if (expire) begin
                    state_d     = MAG_DONE;
                    remaining_d = '0;
                end else if (pause_evt) begin
                    state_d = MAG_PAUSE;
                end else if (tick) begin
                    remaining_d = remaining_q - 1'b1;
                    duty_d      = (duty_q == DUTY_LAST) ? 4'd0 : duty_q + 4'd1;
                end
            end
            MAG_PAUSE: begin
                if (stop_rise) begin
                    state_d     = MAG_IDLE;
                    remaining_d = '0;
                end else if (start_rise && door_closed) begin
                    state_d = MAG_COOK;
                end
            end
            MAG_DONE: begin
                state_d = MAG_IDLE;
            end
            default: begin
                state_d = MAG_IDLE;
            end
        endcase
    end

    // Judged on the state being entered so pulses line up with the state change.
    assign want_d = (state_d == MAG_COOK) & door_closed & (duty_d < power_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MAG_IDLE;
            remaining_q <= '0;
            power_q     <= '0;
            duty_q      <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            mag_set_q   <= 1'b0;
            mag_reset_q <= 1'b1;
            mag_on_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            power_q     <= power_d;
            duty_q      <= duty_d;
            start_q     <= start;
            stop_q      <= stop;
            mag_set_q   <= want_d & ~mag_on_q;
            mag_reset_q <= ~want_d & mag_on_q;
            mag_on_q    <= want_d;
            done_q      <= expire;
        end
    end

    assign mag_set   = mag_set_q;
    assign mag_reset = mag_reset_q;
    assign mag_on    = mag_on_q;
    assign remaining = remaining_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mag_controller.sv
// Directed bench for mag_controller with a fast prescaler (4 cycles per second).
module tb_mag_controller;

    localparam int TPS    = 4;
    localparam int TIME_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              door_closed;
    logic              start;
    logic              stop;
    logic [TIME_W-1:0] time_in;
    logic [3:0]        power_in;
    logic              mag_set;
    logic              mag_reset;
    logic              mag_on;
    logic [TIME_W-1:0] remaining;
    logic [1:0]        state;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    logic latch_q = 1'b1;
    logic excl_en = 1'b0;

    always #5 clk = ~clk;

    mag_controller #(
        .TICKS_PER_SEC(TPS),
        .TIME_W       (TIME_W),
        .DUTY_STEPS   (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .door_closed(door_closed),
        .start      (start),
        .stop       (stop),
        .time_in    (time_in),
        .power_in   (power_in),
        .mag_set    (mag_set),
        .mag_reset  (mag_reset),
        .mag_on     (mag_on),
        .remaining  (remaining),
        .state      (state),
        .done       (done)
    );

    // Behavioural model of the SR latch being driven.
    always @(posedge clk) begin
        if (mag_reset)    latch_q <= 1'b0;
        else if (mag_set) latch_q <= 1'b1;
    end

    assert property (@(posedge clk) !(mag_set && mag_reset));

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (excl_en) chk("set_reset_excl", int'(mag_set & mag_reset), 0);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int sets, resets, done_k;
        rst_n = 1'b0; door_closed = 1'b1; start = 1'b0; stop = 1'b0;
        time_in = '0; power_in = '0;

        // 1. reset
        step(1);
        excl_en = 1'b1;
        chk("rst1_mag_reset", int'(mag_reset), 1);
        chk("rst1_mag_set", int'(mag_set), 0);
        chk("rst1_state", int'(state), 0);
        step(1);
        chk("rst2_mag_reset", int'(mag_reset), 1);
        chk("rst2_remaining", int'(remaining), 0);
        chk("rst2_mag_on", int'(mag_on), 0);
        chk("rst2_done", int'(done), 0);
        chk("rst2_latch_q", int'(latch_q), 0);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_mag_reset", int'(mag_reset), 0);

        // 2. 3 s at full power
        time_in = 3; power_in = 10; start = 1'b1;
        step(1);
        $display("start time=3 power=10: state=%0d mag_set=%0d rem=%0d", state, mag_set, remaining);
        chk("t2_state", int'(state), 1);
        chk("t2_mag_set", int'(mag_set), 1);
        chk("t2_mag_on", int'(mag_on), 1);
        chk("t2_rem0", int'(remaining), 3);
        start = 1'b0;
        step(1);
        chk("t2_set_pulse_len", int'(mag_set), 0);
        chk("t2_latch_on", int'(latch_q), 1);
        step(2);
        chk("t2_rem_before_tick", int'(remaining), 3);
        step(1);
        chk("t2_rem_after_tick", int'(remaining), 2);
        step(8);
        $display("expiry: done=%0d mag_reset=%0d state=%0d rem=%0d", done, mag_reset, state, remaining);
        chk("t2_done", int'(done), 1);
        chk("t2_exp_mag_reset", int'(mag_reset), 1);
        chk("t2_exp_state", int'(state), 3);
        chk("t2_exp_rem", int'(remaining), 0);
        step(1);
        chk("t2_done_len", int'(done), 0);
        chk("t2_idle", int'(state), 0);

        // 3. 10 s at power 3
        time_in = 10; power_in = 3; start = 1'b1;
        sets = 0; resets = 0; done_k = -1;
        for (int k = 0; k < 44; k++) begin
            step(1);
            start = 1'b0;
            sets   += int'(mag_set);
            resets += int'(mag_reset);
            if (done) done_k = k;
            if (k == 11) chk("t3_on_sec2", int'(mag_on), 1);
            if (k == 12) begin
                chk("t3_off_sec3", int'(mag_on), 0);
                chk("t3_rem_sec3", int'(remaining), 7);
            end
        end
        $display("power=3 cook: sets=%0d resets=%0d done_cycle=%0d", sets, resets, done_k);
        chk("t3_sets", sets, 1);
        chk("t3_resets", resets, 1);
        chk("t3_done_cycle", done_k, 40);
        chk("t3_idle", int'(state), 0);

        // duty window wrap, then stop twice (5)
        time_in = 12; power_in = 3; start = 1'b1;
        for (int k = 0; k < 42; k++) begin
            step(1);
            start = 1'b0;
            if (k == 40) begin
                chk("wrap_mag_set", int'(mag_set), 1);
                chk("wrap_rem", int'(remaining), 2);
            end
        end
        stop = 1'b1;
        step(1);
        $display("stop in cook: state=%0d mag_reset=%0d rem=%0d", state, mag_reset, remaining);
        chk("t5_pause", int'(state), 2);
        chk("t5_pause_reset", int'(mag_reset), 1);
        chk("t5_pause_rem", int'(remaining), 2);
        stop = 1'b0;
        step(1);
        stop = 1'b1;
        step(1);
        chk("t5_clear_state", int'(state), 0);
        chk("t5_clear_rem", int'(remaining), 0);
        stop = 1'b0;
        step(1);

        // 4. door opens at remaining=5
        time_in = 10; power_in = 10; start = 1'b1;
        step(1);
        start = 1'b0;
        step(20);
        chk("t4_rem5", int'(remaining), 5);
        door_closed = 1'b0;
        step(1);
        $display("door open: state=%0d mag_reset=%0d rem=%0d", state, mag_reset, remaining);
        chk("t4_door_reset", int'(mag_reset), 1);
        chk("t4_door_pause", int'(state), 2);
        chk("t4_door_rem", int'(remaining), 5);
        step(3);
        chk("t4_hold_rem", int'(remaining), 5);
        door_closed = 1'b1;
        step(2);
        chk("t4_close_no_resume", int'(state), 2);
        chk("t4_close_no_set", int'(mag_set), 0);
        start = 1'b1;
        step(1);
        chk("t4_resume_state", int'(state), 1);
        chk("t4_resume_set", int'(mag_set), 1);
        start = 1'b0;
        step(3);
        chk("t4_resume_rem5", int'(remaining), 5);
        step(1);
        chk("t4_resume_rem4", int'(remaining), 4);

        // start+stop together: in COOK, then in PAUSE, then in IDLE
        start = 1'b1; stop = 1'b1;
        step(1);
        chk("ss_cook_pause", int'(state), 2);
        start = 1'b0; stop = 1'b0;
        step(1);
        start = 1'b1; stop = 1'b1;
        step(1);
        chk("ss_pause_idle", int'(state), 0);
        chk("ss_pause_rem", int'(remaining), 0);
        start = 1'b0; stop = 1'b0;
        step(1);
        time_in = 5; power_in = 5; start = 1'b1; stop = 1'b1;
        step(1);
        chk("ss_idle_state", int'(state), 0);
        chk("ss_idle_set", int'(mag_set), 0);
        start = 1'b0; stop = 1'b0;
        step(1);

        // 6. rejected starts
        time_in = 0; power_in = 5; start = 1'b1;
        step(1);
        chk("t6_time0_state", int'(state), 0);
        chk("t6_time0_set", int'(mag_set), 0);
        start = 1'b0; step(1);
        time_in = 5; power_in = 0; start = 1'b1;
        step(1);
        chk("t6_pow0_state", int'(state), 0);
        start = 1'b0; step(1);
        door_closed = 1'b0; power_in = 5; start = 1'b1;
        step(1);
        chk("t6_door_state", int'(state), 0);
        chk("t6_door_set", int'(mag_set), 0);
        start = 1'b0; door_closed = 1'b1; step(1);

        // expiry coinciding with door-open: DONE wins, reset still issued
        time_in = 1; power_in = 10; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        door_closed = 1'b0;
        step(1);
        $display("expiry+door: state=%0d done=%0d mag_reset=%0d", state, done, mag_reset);
        chk("exp_door_state", int'(state), 3);
        chk("exp_door_done", int'(done), 1);
        chk("exp_door_reset", int'(mag_reset), 1);
        door_closed = 1'b1;
        step(1);
        chk("exp_door_idle", int'(state), 0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
